// File: rtl/viterbi_ber_pkg.sv
// Shared types and default sizing for the Viterbi BER checker.
package viterbi_ber_pkg;

    localparam int DEFAULT_DEPTH = 4096;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ber_delay_ram.sv
// Reference-history circular buffer: one write port, one asynchronous read port, 2-bit words {valid, ref}.
module ber_delay_ram #(
    parameter int DEPTH = viterbi_ber_pkg::DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_data
);

    logic [1:0] mem [DEPTH];

    // Contents are never reset; a run only reads entries it has itself written.
    always_ff @(posedge clk) begin
        mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/viterbi_ber_checker.sv
// Compares decoded bits against the reference stream delayed by the chain latency and counts good/bad bits.
module viterbi_ber_checker #(
    parameter int DEPTH = viterbi_ber_pkg::DEFAULT_DEPTH,
    parameter int CNT_W = viterbi_ber_pkg::DEFAULT_CNT_W,
    parameter int LAT_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ref_i,
    input  logic             ref_valid_i,
    input  logic             dec_i,
    input  logic             start_i,
    input  logic [LAT_W-1:0] latency_i,
    input  logic [CNT_W-1:0] win_len_i,
    output logic [CNT_W-1:0] good_o,
    output logic [CNT_W-1:0] bad_o,
    output logic             err_seen_o,
    output logic [CNT_W-1:0] err_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    import viterbi_ber_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_addr;
    logic [1:0]       rd_data;
    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] fill_left;
    logic [LAT_W-1:0] lat_eff;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] cmp_cnt;
    logic [CNT_W-1:0] cmp_next;
    logic             rd_valid;
    logic             rd_ref;

    assign lat_eff  = (latency_i == '0) ? LAT_W'(1) : latency_i;
    assign rd_addr  = wr_ptr - AW'(lat_q);
    assign rd_valid = rd_data[1];
    assign rd_ref   = rd_data[0];
    assign cmp_next = cmp_cnt + CNT_W'(1);

    ber_delay_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_addr (wr_ptr),
        .wr_data ({ref_valid_i, ref_i}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // History is recorded in every state so the delay line is always primed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(1);
        end
    end

    // start_i restarts from any state, including an in-progress run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            lat_q      <= '0;
            fill_left  <= '0;
            win_q      <= '0;
            cmp_cnt    <= '0;
            good_o     <= '0;
            bad_o      <= '0;
            err_seen_o <= 1'b0;
            err_idx_o  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else if (start_i) begin
            state      <= ST_FILL;
            lat_q      <= lat_eff;
            fill_left  <= lat_eff;
            win_q      <= win_len_i;
            cmp_cnt    <= '0;
            good_o     <= '0;
            bad_o      <= '0;
            err_seen_o <= 1'b0;
            err_idx_o  <= '0;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (fill_left == LAT_W'(1)) begin
                        if (win_q == '0) begin
                            state  <= ST_DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            state <= ST_CHECK;
                        end
                    end else begin
                        fill_left <= fill_left - LAT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (rd_valid) begin
                        if (rd_ref == dec_i) begin
                            good_o <= (good_o == CNT_MAX) ? good_o : good_o + CNT_W'(1);
                        end else begin
                            bad_o <= (bad_o == CNT_MAX) ? bad_o : bad_o + CNT_W'(1);
                            if (!err_seen_o) begin
                                err_seen_o <= 1'b1;
                                err_idx_o  <= cmp_cnt;
                            end
                        end
                        cmp_cnt <= cmp_next;
                        if (cmp_next == win_q) begin
                            state  <= ST_DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Randomized self-checking bench for viterbi_ber_checker against a cycle-indexed reference model.
module tb_viterbi_ber_checker;

    localparam int DEPTH = 4096;
    localparam int CNT_W = 16;
    localparam int LAT_W = 12;
    localparam int ARR   = 512;

    logic             clk = 1'b0;
    logic             rst;
    logic             ref_i;
    logic             ref_valid_i;
    logic             dec_i;
    logic             start_i;
    logic [LAT_W-1:0] latency_i;
    logic [CNT_W-1:0] win_len_i;
    logic [CNT_W-1:0] good_o;
    logic [CNT_W-1:0] bad_o;
    logic             err_seen_o;
    logic [CNT_W-1:0] err_idx_o;
    logic             busy_o;
    logic             done_o;

    int checkCount = 0;
    int passCount  = 0;

    bit refA   [ARR];
    bit validA [ARR];
    bit decA   [ARR];

    int expGood, expBad, expErrSeen, expErrIdx, expDone;

    viterbi_ber_checker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .LAT_W (LAT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ref_i       (ref_i),
        .ref_valid_i (ref_valid_i),
        .dec_i       (dec_i),
        .start_i     (start_i),
        .latency_i   (latency_i),
        .win_len_i   (win_len_i),
        .good_o      (good_o),
        .bad_o       (bad_o),
        .err_seen_o  (err_seen_o),
        .err_idx_o   (err_idx_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            passCount++;
        end
    endtask

    // Random reference, all valid, decoder output = reference delayed by 'delay' edges.
    task automatic buildStream(input int delay);
        for (int k = 0; k < ARR; k++) begin
            refA[k]   = 1'($urandom_range(0, 1));
            validA[k] = 1'b1;
        end
        for (int k = 0; k < ARR; k++) begin
            decA[k] = (k >= delay) ? refA[k - delay] : 1'($urandom_range(0, 1));
        end
    endtask

    // Edge k (start sampled at edge 0) compares dec at k with the entry recorded at edge k-L.
    task automatic computeExpected(input int lat, input int win);
        int leff;
        int cnt;
        leff       = (lat == 0) ? 1 : lat;
        expGood    = 0;
        expBad     = 0;
        expErrSeen = 0;
        expErrIdx  = 0;
        expDone    = -1;
        cnt        = 0;
        if (win == 0) begin
            expDone = leff;
        end else begin
            for (int e = leff + 1; e < ARR; e++) begin
                if (validA[e - leff]) begin
                    if (decA[e] == refA[e - leff]) begin
                        expGood++;
                    end else begin
                        if (expErrSeen == 0) expErrIdx = cnt;
                        expErrSeen = 1;
                        expBad++;
                    end
                    cnt++;
                    if (cnt == win) begin
                        expDone = e;
                        break;
                    end
                end
            end
        end
    endtask

    // Plays the stream from start edge 0; latency/window inputs carry junk outside the start cycle.
    task automatic applyStimulus(input int lat, input int win, input int limit,
                                 input bit stopOnDone, output int doneK);
        doneK = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            start_i     = (k == 0);
            latency_i   = (k == 0) ? LAT_W'(lat) : LAT_W'($urandom);
            win_len_i   = (k == 0) ? CNT_W'(win) : CNT_W'($urandom);
            ref_i       = refA[k];
            ref_valid_i = validA[k];
            dec_i       = decA[k];
            @(posedge clk);
            #1;
            if (done_o && doneK < 0) doneK = k;
            if (stopOnDone && doneK >= 0) break;
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic runAndCheck(input string tag, input int lat, input int win, output int doneK);
        computeExpected(lat, win);
        applyStimulus(lat, win, ARR, 1'b1, doneK);
        checkOutput({tag, ".done_edge"}, doneK, expDone);
        checkOutput({tag, ".good"}, good_o, expGood);
        checkOutput({tag, ".bad"}, bad_o, expBad);
        checkOutput({tag, ".err_seen"}, err_seen_o, expErrSeen);
        checkOutput({tag, ".err_idx"}, err_idx_o, expErrIdx);
        checkOutput({tag, ".busy"}, busy_o, 0);
        checkOutput({tag, ".done"}, done_o, 1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneK;
        int done036;
        int lat;
        int win;
        int delay;

        rst         = 1'b0;
        ref_i       = 1'b0;
        ref_valid_i = 1'b0;
        dec_i       = 1'b0;
        start_i     = 1'b0;
        latency_i   = '0;
        win_len_i   = '0;
        #12;
        checkOutput("reset.good", good_o, 0);
        checkOutput("reset.bad", bad_o, 0);
        checkOutput("reset.err_seen", err_seen_o, 0);
        checkOutput("reset.err_idx", err_idx_o, 0);
        checkOutput("reset.busy", busy_o, 0);
        checkOutput("reset.done", done_o, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] clean run, latency 5, window 100");
        buildStream(5);
        runAndCheck("clean", 5, 100, done036);
        checkOutput("clean.good_100", good_o, 100);
        checkOutput("clean.done_105", done036, 105);

        $display("[TB] single error at comparison 10");
        buildStream(5);
        decA[5 + 1 + 10] = ~decA[5 + 1 + 10];
        runAndCheck("err10", 5, 100, doneK);
        checkOutput("err10.err_idx_10", err_idx_o, 10);
        checkOutput("err10.bad_1", bad_o, 1);

        $display("[TB] latency 4 against true delay 5, alternating reference");
        for (int k = 0; k < ARR; k++) begin
            refA[k]   = 1'(k % 2);
            validA[k] = 1'b1;
            decA[k]   = (k >= 5) ? 1'((k - 5) % 2) : 1'b0;
        end
        runAndCheck("misalign", 4, 100, doneK);
        checkOutput("misalign.bad_100", bad_o, 100);

        $display("[TB] reference invalid for 20 cycles mid-window");
        buildStream(5);
        for (int k = 40; k < 60; k++) validA[k] = 1'b0;
        runAndCheck("gap", 5, 100, doneK);
        checkOutput("gap.done_plus20", doneK, done036 + 20);

        $display("[TB] reset at comparison 50");
        buildStream(5);
        applyStimulus(5, 100, 5 + 1 + 50 + 1, 1'b0, doneK);
        checkOutput("rstmid.busy_before", busy_o, 1);
        rst = 1'b0;
        #1;
        checkOutput("rstmid.good", good_o, 0);
        checkOutput("rstmid.bad", bad_o, 0);
        checkOutput("rstmid.err_seen", err_seen_o, 0);
        checkOutput("rstmid.err_idx", err_idx_o, 0);
        checkOutput("rstmid.busy", busy_o, 0);
        checkOutput("rstmid.done", done_o, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rstmid.idle_busy", busy_o, 0);
        checkOutput("rstmid.idle_good", good_o, 0);
        buildStream(5);
        runAndCheck("afterrst", 5, 100, doneK);
        checkOutput("afterrst.good_100", good_o, 100);

        $display("[TB] zero window, then zero latency");
        buildStream(5);
        runAndCheck("win0", 5, 0, doneK);
        buildStream(1);
        runAndCheck("lat0", 0, 100, doneK);
        checkOutput("lat0.good_100", good_o, 100);

        $display("[TB] abort a run with a new start");
        buildStream(8);
        applyStimulus(8, 50, 30, 1'b0, doneK);
        checkOutput("abort.busy_mid", busy_o, 1);
        buildStream(3);
        runAndCheck("abort", 3, 40, doneK);

        $display("[TB] randomized runs");
        for (int r = 0; r < 6; r++) begin
            lat   = $urandom_range(0, 20);
            win   = $urandom_range(1, 60);
            delay = (lat == 0) ? 1 : lat;
            buildStream(delay);
            for (int k = 0; k < ARR; k++) begin
                if ($urandom_range(0, 3) == 0) validA[k] = 1'b0;
                if ($urandom_range(0, 7) == 0) decA[k] = ~decA[k];
            end
            runAndCheck($sformatf("rand%0d", r), lat, win, doneK);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_checker.md
VITERBI_BER_CHECKER -- requirements
Module: viterbi_ber_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, reference-history depth; power of 2.
REQ-002 SHALL have parameter CNT_W, default 16, width of all counters.
REQ-003 SHALL have parameter LAT_W, default $clog2(DEPTH), width of latency_i.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port ref_i  input  1  original data bit feeding the encoder (encoder_i).
REQ-007 SHALL have port ref_valid_i  input  1  ref_i qualifier (enable_encoder_i).
REQ-008 SHALL have port dec_i  input  1  decoded bit from the tx/rx chain (decoder_o).
REQ-009 SHALL have port start_i  input  1  single-cycle pulse that begins a measurement.
REQ-010 SHALL have port latency_i  input  LAT_W  chain latency L in cycles, sampled on start_i.
REQ-011 SHALL have port win_len_i  input  CNT_W  number of valid comparisons per run, sampled on start_i.
REQ-012 SHALL have port good_o  output  CNT_W  matching-bit count.
REQ-013 SHALL have port bad_o  output  CNT_W  mismatching-bit count.
REQ-014 SHALL have port err_seen_o  output  1  at least one mismatch this run.
REQ-015 SHALL have port err_idx_o  output  CNT_W  comparison index (0-based) of first mismatch.
REQ-016 SHALL have port busy_o  output  1  high in FILL or CHECK.
REQ-017 SHALL have port done_o  output  1  high in DONE.

Function
REQ-018 SHALL write {ref_valid_i, ref_i} into a circular buffer every cycle, write pointer incrementing mod DEPTH, in all states.
REQ-019 SHALL compare dec_i at cycle t with the entry written at cycle t-L; latency_i=0 SHALL be treated as L=1; L<=DEPTH-1.
REQ-020 SHALL implement FSM IDLE, FILL, CHECK, DONE.
REQ-021 IDLE: on start_i, latch L and win_len, clear good/bad/err_seen/err_idx and compare count, go FILL.
REQ-022 FILL: wait L cycles, then go CHECK; if latched win_len=0 go DONE instead.
REQ-023 CHECK: entries with valid=0 SHALL be skipped (no count change); valid entries SHALL increment good or bad and the compare count.
REQ-024 On the first mismatch of a run, err_seen_o SHALL set and err_idx_o SHALL capture the compare count; later mismatches SHALL not alter err_idx_o.
REQ-025 When compare count reaches win_len, FSM SHALL go DONE; done_o rises the cycle after the last comparison.
REQ-026 DONE: outputs hold; start_i SHALL restart per REQ-021.
REQ-027 start_i in FILL or CHECK SHALL abort the run and restart per REQ-021.
REQ-028 good_o and bad_o SHALL saturate at 2^CNT_W-1, never wrap.
REQ-029 All outputs SHALL be registered; counter updates visible one cycle after the compared edge.
REQ-030 latency_i and win_len_i changes outside start_i SHALL be ignored.

Reset
REQ-031 rst low SHALL immediately force IDLE and drive good_o, bad_o, err_idx_o to 0 and err_seen_o, busy_o, done_o to 0.
REQ-032 Reset SHALL clear the write pointer; buffer contents need not be cleared, because the first run's FILL of L cycles overwrites every read entry.
REQ-033 Reset mid-run SHALL discard the run; no output resumes until a new start_i.

Structure
REQ-034 Package viterbi_ber_pkg SHALL hold the FSM state enum and default DEPTH and CNT_W constants.
REQ-035 Circular buffer SHALL be sub-module ber_delay_ram (1 write, 1 read port, 2-bit words); FSM and counters SHALL be in viterbi_ber_checker.

Verification
REQ-036 Bench SHALL drive dec_i equal to ref_i delayed 5 cycles, latency 5, win 100, random ref -> good=100, bad=0, err_seen=0, done after 105 cycles.
REQ-037 Bench SHALL repeat with dec_i inverted at comparison 10 -> good=99, bad=1, err_seen=1, err_idx=10.
REQ-038 Bench SHALL use latency 4 with true delay 5 and ref pattern 1010 -> good=0, bad=100, err_idx=0.
REQ-039 Bench SHALL hold ref_valid_i low 20 cycles mid-window, win 100 -> good=100, done 20 cycles later than in REQ-036.
REQ-040 Bench SHALL pulse rst low at comparison 50 -> all outputs 0 at once; a new start_i then gives a clean 100/0 run.
REQ-041 Bench SHALL start with win 0 then latency 0 -> DONE after FILL with zero counts; latency 0 compares at 1-cycle delay.
